// File: rtl/kernel_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : kernel_dispatcher_if
// Description : Launch handshake and core-facing bus of the kernel dispatcher.
//               The master side is the host plus the core. The slave side is
//               the dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface kernel_dispatcher_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // Host launch channel
  logic                  launch_valid;
  logic                  launch_ready;
  logic [ADDR_WIDTH-1:0] launch_pc;
  logic [DATA_WIDTH-1:0] launch_grid_dim;
  logic [DATA_WIDTH-1:0] launch_block_dim;

  // Core sequencing
  logic                  core_start;
  logic [ADDR_WIDTH-1:0] core_pc_start;
  logic [DATA_WIDTH-1:0] thread_idx;
  logic [DATA_WIDTH-1:0] block_idx;
  logic [DATA_WIDTH-1:0] block_dim;
  logic [DATA_WIDTH-1:0] grid_dim;
  logic [DATA_WIDTH-1:0] warp_idx;
  logic [DATA_WIDTH-1:0] lane_idx;
  logic                  core_done;

  // Status
  logic                  busy;
  logic                  kernel_done;
  logic                  timeout_err;
  logic [DATA_WIDTH-1:0] threads_run;

  modport master (
    output launch_valid, launch_pc, launch_grid_dim, launch_block_dim, core_done,
    input  launch_ready, core_start, core_pc_start, thread_idx, block_idx,
           block_dim, grid_dim, warp_idx, lane_idx, busy, kernel_done,
           timeout_err, threads_run
  );

  modport slave (
    input  launch_valid, launch_pc, launch_grid_dim, launch_block_dim, core_done,
    output launch_ready, core_start, core_pc_start, thread_idx, block_idx,
           block_dim, grid_dim, warp_idx, lane_idx, busy, kernel_done,
           timeout_err, threads_run
  );
endinterface
`default_nettype wire

// File: rtl/kernel_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : kernel_dispatcher
// Description : Accepts one kernel launch and runs the core once for each
//               (block, thread) pair, in order. It presents the thread, block,
//               warp and lane identifiers for each run, waits for core_done
//               between runs and flags a per-thread timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module kernel_dispatcher #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int WARP_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  wire logic           clk,
  input  wire logic           rst,
  kernel_dispatcher_if.slave  bus
);

  // Warp/lane split: WARP_SIZE is a power of two, so a shift and a mask suffice
  localparam int                    WARP_SHIFT = $clog2(WARP_SIZE);
  localparam logic [DATA_WIDTH-1:0] LANE_MASK  = DATA_WIDTH'(WARP_SIZE - 1);

  // The watchdog counter must be able to hold TIMEOUT_CYCLES after its last increment
  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    GUARD   = 3'd2,
    WAIT    = 3'd3,
    ADVANCE = 3'd4,
    FINISH  = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  // Latched launch parameters
  logic [ADDR_WIDTH-1:0] latched_pc;
  logic [DATA_WIDTH-1:0] latched_grid;
  logic [DATA_WIDTH-1:0] latched_block;

  // Position in the (block, thread) walk
  logic [DATA_WIDTH-1:0] thread_cur;
  logic [DATA_WIDTH-1:0] block_cur;

  // Status registers
  logic [DATA_WIDTH-1:0] run_count;
  logic                  timeout_flag;
  logic [CNT_W-1:0]      wait_count;

  // FSM decode
  logic accept;
  logic take_done;
  logic take_timeout;
  logic start_pulse;
  logic done_pulse;
  logic idle_now;

  // End-of-walk compares. A dim is never 0 once a run has started, so dim-1 cannot wrap.
  logic last_thread;
  logic last_block;
  logic wait_expired;

  assign last_thread  = (thread_cur == (latched_block - DATA_WIDTH'(1)));
  assign last_block   = (block_cur  == (latched_grid  - DATA_WIDTH'(1)));
  assign wait_expired = (wait_count == WAIT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    take_done    = 1'b0;
    take_timeout = 1'b0;
    start_pulse  = 1'b0;
    done_pulse   = 1'b0;
    idle_now     = 1'b0;
    case (state)
      IDLE: begin
        idle_now = 1'b1;
        if (bus.launch_valid) begin
          accept = 1'b1;
          if ((bus.launch_grid_dim == '0) || (bus.launch_block_dim == '0)) begin
            state_next = FINISH;
          end else begin
            state_next = START;
          end
        end
      end
      START: begin
        start_pulse = 1'b1;
        state_next  = GUARD;
      end
      GUARD: begin
        // A done still high from the previous run is not taken as completion here
        state_next = WAIT;
      end
      WAIT: begin
        if (bus.core_done) begin
          take_done  = 1'b1;
          state_next = ADVANCE;
        end else if (wait_expired) begin
          take_timeout = 1'b1;
          state_next   = FINISH;
        end
      end
      ADVANCE: begin
        if (last_thread && last_block) begin
          state_next = FINISH;
        end else begin
          state_next = START;
        end
      end
      FINISH: begin
        done_pulse = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the launch parameters when a launch is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latched_pc    <= '0;
      latched_grid  <= '0;
      latched_block <= '0;
    end else if (accept) begin
      latched_pc    <= bus.launch_pc;
      latched_grid  <= bus.launch_grid_dim;
      latched_block <= bus.launch_block_dim;
    end
  end

  // Step through threads within a block, then through blocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thread_cur <= '0;
      block_cur  <= '0;
    end else if (accept) begin
      thread_cur <= '0;
      block_cur  <= '0;
    end else if (state == ADVANCE) begin
      if (last_thread) begin
        thread_cur <= '0;
        if (!last_block) begin
          block_cur <= block_cur + DATA_WIDTH'(1);
        end
      end else begin
        thread_cur <= thread_cur + DATA_WIDTH'(1);
      end
    end
  end

  // Per-thread watchdog: zero on entry to WAIT, one step per WAIT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_count <= '0;
    end else if (state == GUARD) begin
      wait_count <= '0;
    end else if (state == WAIT) begin
      wait_count <= wait_count + CNT_W'(1);
    end
  end

  // Completed-run count and sticky timeout flag, cleared only by a new launch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_count    <= '0;
      timeout_flag <= 1'b0;
    end else if (accept) begin
      run_count    <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (take_done) begin
        run_count <= run_count + DATA_WIDTH'(1);
      end
      if (take_timeout) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  assign bus.launch_ready  = idle_now;
  assign bus.busy          = !idle_now;
  assign bus.core_start    = start_pulse;
  assign bus.kernel_done   = done_pulse;
  assign bus.core_pc_start = latched_pc;
  assign bus.thread_idx    = thread_cur;
  assign bus.block_idx     = block_cur;
  assign bus.block_dim     = latched_block;
  assign bus.grid_dim      = latched_grid;
  assign bus.warp_idx      = thread_cur >> WARP_SHIFT;
  assign bus.lane_idx      = thread_cur & LANE_MASK;
  assign bus.threads_run   = run_count;
  assign bus.timeout_err   = timeout_flag;

endmodule
`default_nettype wire

// File: tb/tb_kernel_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_kernel_dispatcher
// Description : Self-checking bench for kernel_dispatcher. A launch-level
//               reference model predicts every cycle's outputs. Directed
//               kernels pin the model with literal expectations, and random
//               kernels with random core latencies follow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kernel_dispatcher;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int WS = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  kernel_dispatcher_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  kernel_dispatcher #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WARP_SIZE(WS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state (owned by the compare process) ----
  int          cyc = 0;
  bit          m_busy = 0;
  bit          busy_now;
  int          exp_start = -1;
  int          exp_kdone = -1;
  int          win_start = 0;
  bit          run_active = 0;
  logic [31:0] m_pc = 0, m_grid = 0, m_block = 0, m_tr = 0;
  bit          m_terr = 0;
  int          q_blk[$];
  int          q_thr[$];

  // Observation logs (cleared by the stimulus between directed tests)
  int          st_blk[$], st_thr[$], st_warp[$], st_lane[$], st_cyc[$];
  logic [31:0] st_pc[$];
  int          kd_cyc[$], acc_cyc[$];

  // Compare process: check this cycle's outputs, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 0; exp_start = -1; exp_kdone = -1; run_active = 0;
      m_pc = 0; m_grid = 0; m_block = 0; m_tr = 0; m_terr = 0;
      q_blk.delete(); q_thr.delete();
    end else begin
      if (bus.core_start === 1'b1) begin
        st_blk.push_back(int'(bus.block_idx)); st_thr.push_back(int'(bus.thread_idx));
        st_warp.push_back(int'(bus.warp_idx)); st_lane.push_back(int'(bus.lane_idx));
        st_pc.push_back(bus.core_pc_start);    st_cyc.push_back(cyc);
      end
      if (bus.kernel_done === 1'b1) kd_cyc.push_back(cyc);

      check("busy",         64'(bus.busy),         64'(m_busy));
      check("launch_ready", 64'(bus.launch_ready), 64'(!m_busy));
      check("core_start",   64'(bus.core_start),   64'(cyc == exp_start));
      check("kernel_done",  64'(bus.kernel_done),  64'(cyc == exp_kdone));
      check("threads_run",  64'(bus.threads_run),  64'(m_tr));
      check("timeout_err",  64'(bus.timeout_err),  64'(m_terr));
      check("grid_dim",     64'(bus.grid_dim),     64'(m_grid));
      check("block_dim",    64'(bus.block_dim),    64'(m_block));
      if (cyc == exp_start && q_thr.size() > 0) begin
        check("thread_idx",    64'(bus.thread_idx),    64'(q_thr[0]));
        check("block_idx",     64'(bus.block_idx),     64'(q_blk[0]));
        check("warp_idx",      64'(bus.warp_idx),      64'(q_thr[0] / WS));
        check("lane_idx",      64'(bus.lane_idx),      64'(q_thr[0] % WS));
        check("core_pc_start", 64'(bus.core_pc_start), 64'(m_pc));
      end

      busy_now = m_busy;
      if (cyc == exp_kdone) begin
        m_busy = 0; exp_kdone = -1;
      end
      if (cyc == exp_start) begin
        run_active = 1; win_start = cyc + 2; exp_start = -1;
      end else if (run_active && cyc >= win_start) begin
        if (bus.core_done === 1'b1) begin
          m_tr = m_tr + 1;
          void'(q_blk.pop_front()); void'(q_thr.pop_front());
          run_active = 0;
          if (q_thr.size() > 0) exp_start = cyc + 2;
          else                  exp_kdone = cyc + 2;
        end else if (cyc - win_start == TO - 1) begin
          m_terr = 1; run_active = 0;
          q_blk.delete(); q_thr.delete();
          exp_kdone = cyc + 1;
        end
      end
      if (!busy_now && bus.launch_valid === 1'b1) begin
        m_busy = 1;
        m_pc = bus.launch_pc; m_grid = bus.launch_grid_dim; m_block = bus.launch_block_dim;
        m_tr = 0; m_terr = 0;
        acc_cyc.push_back(cyc);
        for (int b = 0; b < int'(m_grid); b++)
          for (int t = 0; t < int'(m_block); t++) begin
            q_blk.push_back(b); q_thr.push_back(t);
          end
        if (q_thr.size() == 0) exp_kdone = cyc + 1;
        else                   exp_start = cyc + 1;
      end
    end
  end

  // ---------------- core responder -------------------------------------------
  // 0: random latency (sometimes never, sometimes held over), 1: always high,
  // 2: never, 3: one-cycle pulse 3 cycles after start
  int done_mode = 3;

  initial begin
    int ra;
    int hold;
    ra = 0;
    hold = 0;
    bus.core_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        ra = 0; hold = 0; bus.core_done = 1'b0;
      end else if (done_mode == 1) begin
        bus.core_done = 1'b1;
      end else if (done_mode == 2) begin
        ra = 0; hold = 0; bus.core_done = 1'b0;
      end else begin
        if (bus.core_start === 1'b1) begin
          if (done_mode == 3)                  ra = 3;
          else if ($urandom_range(0, 7) == 0)  ra = 0;
          else                                 ra = int'($urandom_range(2, 9));
        end else if (ra > 0) begin
          ra--;
          if (ra == 0) hold = (done_mode == 3) ? 1 : int'($urandom_range(1, 3));
        end
        bus.core_done = (hold > 0);
        if (hold > 0) hold--;
      end
    end
  end

  // ---------------- stimulus helpers -----------------------------------------
  task automatic clear_logs();
    st_blk.delete(); st_thr.delete(); st_warp.delete(); st_lane.delete();
    st_pc.delete(); st_cyc.delete(); kd_cyc.delete(); acc_cyc.delete();
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic do_launch(input logic [31:0] pc, input logic [31:0] g, input logic [31:0] b);
    int k;
    k = 0;
    bus.launch_pc = pc; bus.launch_grid_dim = g; bus.launch_block_dim = b;
    bus.launch_valid = 1'b1;
    @(negedge clk);
    while (bus.launch_ready !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("launch_accept_wait", 64'(bus.launch_ready), 64'(1));
    @(posedge clk); #1;
    bus.launch_valid = 1'b0;
  endtask

  task automatic wait_kdone(input int n_before);
    int k;
    k = 0;
    while (kd_cyc.size() <= n_before && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check("kernel_done_wait", 64'(kd_cyc.size() > n_before), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  // ---------------- main sequence ---------------------------------------------
  initial begin
    bus.launch_valid = 1'b0; bus.launch_pc = '0;
    bus.launch_grid_dim = '0; bus.launch_block_dim = '0;
    #2 rst = 1'b1;
    #1;
    check("rst_launch_ready", 64'(bus.launch_ready), 64'(1));
    check("rst_busy",         64'(bus.busy),         64'(0));
    check("rst_core_start",   64'(bus.core_start),   64'(0));
    check("rst_threads_run",  64'(bus.threads_run),  64'(0));
    check("rst_pc",           64'(bus.core_pc_start), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single thread
    done_mode = 3; clear_logs();
    do_launch(32'h40, 1, 1);
    wait_kdone(0);
    repeat (3) @(posedge clk); #1;
    check("t1_starts", 64'(st_pc.size()), 64'(1));
    if (st_pc.size() == 1) begin
      check("t1_pc",     64'(st_pc[0]),  64'(32'h40));
      check("t1_thread", 64'(st_thr[0]), 64'(0));
      check("t1_block",  64'(st_blk[0]), 64'(0));
      check("t1_latency", 64'(kd_cyc[0] - st_cyc[0]), 64'(5));
      check("t1_first_start", 64'(st_cyc[0] - acc_cyc[0]), 64'(1));
    end
    check("t1_threads_run", 64'(bus.threads_run), 64'(1));
    check("t1_kdone_count", 64'(kd_cyc.size()),   64'(1));
    check("t1_busy",        64'(bus.busy),        64'(0));

    // Index walk
    clear_logs();
    do_launch(32'h100, 2, 3);
    wait_kdone(0);
    check("t2_starts", 64'(st_thr.size()), 64'(6));
    if (st_thr.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("t2_block_order",  64'(st_blk[i]), 64'(i / 3));
        check("t2_thread_order", 64'(st_thr[i]), 64'(i % 3));
      end
      check("t2_spacing", 64'(st_cyc[1] - st_cyc[0]), 64'(5));
    end
    check("t2_threads_run", 64'(bus.threads_run), 64'(6));
    check("t2_block_dim",   64'(bus.block_dim),   64'(3));
    check("t2_grid_dim",    64'(bus.grid_dim),    64'(2));

    // Warp/lane split
    clear_logs();
    do_launch(32'h200, 1, 10);
    wait_kdone(0);
    check("t3_starts", 64'(st_thr.size()), 64'(10));
    if (st_thr.size() == 10) begin
      check("t3_warp9", 64'(st_warp[9]), 64'(2));
      check("t3_lane9", 64'(st_lane[9]), 64'(1));
      check("t3_warp4", 64'(st_warp[4]), 64'(1));
      check("t3_lane4", 64'(st_lane[4]), 64'(0));
    end

    // Zero dims
    clear_logs();
    do_launch(32'h300, 0, 5);
    wait_kdone(0);
    repeat (2) @(posedge clk); #1;
    check("t4_starts",      64'(st_thr.size()),   64'(0));
    check("t4_threads_run", 64'(bus.threads_run), 64'(0));
    check("t4_kdone_count", 64'(kd_cyc.size()),   64'(1));
    if (kd_cyc.size() == 1) check("t4_kdone_delay", 64'(kd_cyc[0] - acc_cyc[0]), 64'(1));

    // Timeout
    done_mode = 2; clear_logs();
    do_launch(32'h400, 1, 4);
    wait_kdone(0);
    repeat (3) @(posedge clk); #1;
    check("t5_timeout_err", 64'(bus.timeout_err), 64'(1));
    check("t5_threads_run", 64'(bus.threads_run), 64'(0));
    check("t5_starts",      64'(st_thr.size()),   64'(1));
    if (st_thr.size() == 1 && kd_cyc.size() == 1)
      check("t5_abort_latency", 64'(kd_cyc[0] - st_cyc[0]), 64'(10));

    // Stale done held high
    done_mode = 1; clear_logs();
    do_launch(32'h500, 1, 3);
    wait_kdone(0);
    check("t6_threads_run", 64'(bus.threads_run), 64'(3));
    check("t6_timeout_clr", 64'(bus.timeout_err), 64'(0));
    if (st_cyc.size() == 3) begin
      check("t6_gap01", 64'(st_cyc[1] - st_cyc[0]), 64'(4));
      check("t6_gap12", 64'(st_cyc[2] - st_cyc[1]), 64'(4));
    end

    // Backpressure: second launch presented while busy
    done_mode = 3; clear_logs();
    @(posedge clk); #1;
    do_launch(32'h600, 1, 2);
    do_launch(32'h700, 1, 1);
    wait_kdone(1);
    check("t7_accepts", 64'(acc_cyc.size()), 64'(2));
    if (acc_cyc.size() == 2 && kd_cyc.size() >= 1)
      check("t7_accept_after_idle", 64'(acc_cyc[1] - kd_cyc[0]), 64'(1));
    check("t7_threads_run", 64'(bus.threads_run), 64'(1));

    // Random kernels with random core latency
    done_mode = 0;
    for (int n = 0; n < 25; n++) begin
      clear_logs();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_launch($urandom(), $urandom_range(0, 3), $urandom_range(0, 4));
      wait_kdone(0);
    end

    // Reset in the middle of WAIT
    done_mode = 2; clear_logs();
    @(posedge clk); #1;
    do_launch(32'h800, 2, 2);
    for (int k = 0; k < 20 && st_cyc.size() == 0; k++) begin
      @(posedge clk); #1;
    end
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("r_launch_ready", 64'(bus.launch_ready), 64'(1));
    check("r_busy",         64'(bus.busy),         64'(0));
    check("r_thread_idx",   64'(bus.thread_idx),   64'(0));
    check("r_block_idx",    64'(bus.block_idx),    64'(0));
    check("r_grid_dim",     64'(bus.grid_dim),     64'(0));
    check("r_block_dim",    64'(bus.block_dim),    64'(0));
    check("r_pc",           64'(bus.core_pc_start), 64'(0));
    check("r_core_start",   64'(bus.core_start),   64'(0));
    check("r_kernel_done",  64'(bus.kernel_done),  64'(0));
    check("r_threads_run",  64'(bus.threads_run),  64'(0));
    check("r_timeout_err",  64'(bus.timeout_err),  64'(0));
    @(posedge clk); #1 rst = 1'b0;
    done_mode = 3; clear_logs();
    @(posedge clk); #1;
    do_launch(32'h900, 1, 2);
    wait_kdone(0);
    check("r_recover_threads", 64'(bus.threads_run), 64'(2));

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
